// File: rtl/fifo_ptr_sync_pkg.sv
// Shared constants and helpers for the gray-pointer synchroniser.
// Default widths and depths used by the FIFO instances.
package fifo_ptr_sync_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_STAGES = 2;

  // Pointer carries one extra wrap bit above the address.
  localparam int DEF_PTR_W = DEF_ADDR_W + 1;
  localparam int MAX_PTR_W = 16;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  // True when more than one bit is set: a legal gray step flips exactly one.
  function automatic logic multi_bit(input ptr_max_t x);
    return (x & (x - ptr_max_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync_if.sv
// Signal bundle between a FIFO side and its pointer synchroniser.
// master = the consuming FIFO logic, slave = the synchroniser itself.
interface fifo_ptr_sync_if
  import fifo_ptr_sync_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W
);
  logic [PTR_W-1:0] sync_in;
  logic             sync_err_clr;
  logic [PTR_W-1:0] sync_out;
  logic [PTR_W-1:0] sync_bin;
  logic [PTR_W-1:0] sync_delta;
  logic             sync_adv;
  logic             sync_valid;
  logic             sync_err;

  modport master (
    output sync_in, sync_err_clr,
    input  sync_out, sync_bin, sync_delta, sync_adv, sync_valid, sync_err
  );

  modport slave (
    input  sync_in, sync_err_clr,
    output sync_out, sync_bin, sync_delta, sync_adv, sync_valid, sync_err
  );
endinterface

// File: rtl/fifo_ptr_sync_gray2bin.sv
// Combinational gray-to-binary converter, shared with the FIFO full/empty logic.
// Each binary bit is the xor of all gray bits at and above its position.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Prefix-xor from the MSB down, written per bit to avoid a feedback chain.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/fifo_ptr_sync.sv
// Gray-pointer synchroniser: configurable flop chain into sync_clk, binary
// conversion, per-cycle advance distance, and a sticky multi-bit-step flag.
module fifo_ptr_sync
  import fifo_ptr_sync_pkg::*;
#(
  parameter int PTR_W    = DEF_PTR_W,
  parameter int STAGES   = DEF_STAGES,
  parameter int CHECK_EN = 1
) (
  input  logic          sync_clk,
  input  logic          sync_rst,
  fifo_ptr_sync_if.slave bus
);

  localparam int                CNT_W   = $clog2(STAGES + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STAGES + 1);

  // Saturating warm-up increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] r_chain [STAGES];
  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_delta;
  logic             r_adv;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_out;
  logic [PTR_W-1:0] w_bin;
  logic [PTR_W-1:0] w_delta;
  logic             w_valid;
  logic             w_err;

  assign w_out   = r_chain[STAGES-1];
  assign w_delta = w_bin - r_bin;
  assign w_valid = (r_cnt == CNT_MAX);

  // Plain flop chain; nothing between stages so each flop only resolves metastability.
  always_ff @(posedge sync_clk or posedge sync_rst) begin
    if (sync_rst) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= bus.sync_in;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  gray2bin #(.W(PTR_W)) u_gray2bin (
    .i_gray (w_out),
    .o_bin  (w_bin)
  );

  // Warm-up counter: outputs are trusted only once the chain holds post-reset data.
  always_ff @(posedge sync_clk or posedge sync_rst) begin
    if (sync_rst) r_cnt <= '0;
    else          r_cnt <= sat_inc(r_cnt);
  end

  // ---- stage p1: registered binary, advance distance and advance pulse ----
  // Delta and pulse are held at zero during warm-up so reset flush is not seen as motion.
  always_ff @(posedge sync_clk or posedge sync_rst) begin
    if (sync_rst) begin
      r_bin   <= '0;
      r_delta <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_bin   <= w_bin;
      r_delta <= w_valid ? w_delta : '0;
      r_adv   <= w_valid && (w_delta != '0);
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_check
      logic [PTR_W-1:0] r_prev;
      logic             r_err;
      logic             w_jump;

      assign w_jump = multi_bit(ptr_max_t'(w_out ^ r_prev));
      assign w_err  = r_err;

      // Previous synchronised gray, compared against the current one each cycle.
      always_ff @(posedge sync_clk or posedge sync_rst) begin
        if (sync_rst) r_prev <= '0;
        else          r_prev <= w_out;
      end

      // Sticky error; a new violation outranks a clear in the same cycle.
      always_ff @(posedge sync_clk or posedge sync_rst) begin
        if (sync_rst)                r_err <= 1'b0;
        else if (w_valid && w_jump)  r_err <= 1'b1;
        else if (bus.sync_err_clr)   r_err <= 1'b0;
      end
    end else begin : g_nocheck
      logic w_unused_clr;
      assign w_unused_clr = bus.sync_err_clr;
      assign w_err        = 1'b0;
    end
  endgenerate

  assign bus.sync_out   = w_out;
  assign bus.sync_bin   = r_bin;
  assign bus.sync_delta = r_delta;
  assign bus.sync_adv   = r_adv;
  assign bus.sync_valid = w_valid;
  assign bus.sync_err   = w_err;

endmodule

// File: tb/tb_fifo_ptr_sync.sv
// Bench for fifo_ptr_sync: two builds (STAGES=2 checked, STAGES=4 unchecked)
// driven by the same pointer stream and compared every cycle to an edge-indexed
// history model, plus directed spot checks of the headline behaviours.
module tb_fifo_ptr_sync;
  localparam int W    = 5;
  localparam int MASK = (1 << W) - 1;
  localparam int HMAX = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] r_in;
  logic         r_clr;

  always #5 clk = ~clk;

  fifo_ptr_sync_if #(.PTR_W(W)) if0 ();
  fifo_ptr_sync_if #(.PTR_W(W)) if1 ();

  assign if0.sync_in      = r_in;
  assign if0.sync_err_clr = r_clr;
  assign if1.sync_in      = r_in;
  assign if1.sync_err_clr = r_clr;

  fifo_ptr_sync #(.PTR_W(W), .STAGES(2), .CHECK_EN(1)) dut0 (
    .sync_clk (clk),
    .sync_rst (rst),
    .bus      (if0)
  );

  fifo_ptr_sync #(.PTR_W(W), .STAGES(4), .CHECK_EN(0)) dut1 (
    .sync_clk (clk),
    .sync_rst (rst),
    .bus      (if1)
  );

  int checks = 0;
  int errors = 0;
  int k      = 0;
  int in_h  [HMAX];
  int err_e [2][HMAX];
  int stg   [2] = '{2, 4};
  int chken [2] = '{1, 0};

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & MASK;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  // Value on the last chain stage after rising edge j since reset release.
  function automatic int out_at(input int d, input int j);
    int src = j - stg[d] + 1;
    return (j >= 1 && src >= 1) ? in_h[src] : 0;
  endfunction

  function automatic int bin_at(input int d, input int j);
    return (j >= 1) ? g2b(out_at(d, j - 1)) : 0;
  endfunction

  function automatic int valid_at(input int d, input int j);
    return (j >= stg[d] + 1) ? 1 : 0;
  endfunction

  function automatic int delta_at(input int d, input int j);
    if (j >= 1 && valid_at(d, j - 1) == 1) return (bin_at(d, j) - bin_at(d, j - 1)) & MASK;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [W-1:0] o, input logic [W-1:0] b,
                           input logic [W-1:0] dl, input logic a, input logic v, input logic e);
    int de;
    de = delta_at(d, k);
    chk($sformatf("d%0d.out k=%0d", d, k),   16'(o),  16'(out_at(d, k)));
    chk($sformatf("d%0d.bin k=%0d", d, k),   16'(b),  16'(bin_at(d, k)));
    chk($sformatf("d%0d.delta k=%0d", d, k), 16'(dl), 16'(de));
    chk($sformatf("d%0d.adv k=%0d", d, k),   16'(a),  16'(de != 0));
    chk($sformatf("d%0d.valid k=%0d", d, k), 16'(v),  16'(valid_at(d, k)));
    chk($sformatf("d%0d.err k=%0d", d, k),   16'(e),  16'(err_e[d][k]));
  endtask

  task automatic check_all();
    check_dut(0, if0.sync_out, if0.sync_bin, if0.sync_delta, if0.sync_adv, if0.sync_valid, if0.sync_err);
    check_dut(1, if1.sync_out, if1.sync_bin, if1.sync_delta, if1.sync_adv, if1.sync_valid, if1.sync_err);
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    int set;
    @(posedge clk);
    if (!rst && k < HMAX - 1) begin
      k++;
      in_h[k] = int'(r_in);
      for (int d = 0; d < 2; d++) begin
        set = (chken[d] == 1 && valid_at(d, k - 1) == 1 &&
               $countones(out_at(d, k - 1) ^ out_at(d, k - 2)) > 1) ? 1 : 0;
        err_e[d][k] = (set == 1) ? 1 : (r_clr ? 0 : err_e[d][k - 1]);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  // Assert reset asynchronously away from the clock edge and check the cleared state.
  task automatic assert_reset(input int hold);
    rst = 1'b1;
    #1;
    k = 0;
    err_e[0][0] = 0;
    err_e[1][0] = 0;
    check_all();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  task automatic warmup_checks(input string tag);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("%s d0.valid e%0d", tag, e), 16'(if0.sync_valid), 16'(e >= 3));
      chk($sformatf("%s d1.valid e%0d", tag, e), 16'(if1.sync_valid), 16'(e >= 5));
      chk($sformatf("%s d0.adv e%0d", tag, e),   16'(if0.sync_adv),   16'(0));
      chk($sformatf("%s d0.err e%0d", tag, e),   16'(if0.sync_err),   16'(0));
    end
  endtask

  initial begin
    int b;
    int r;
    rst   = 1'b1;
    r_in  = '0;
    r_clr = 1'b0;
    @(negedge clk);

    // Reset, then hold zero through warm-up.
    assert_reset(2);
    warmup_checks("init");

    // Gray count 1..33, one step per cycle, crossing the 31 -> 0 wrap.
    for (int i = 1; i <= 33; i++) begin
      r_in = W'(b2g(i & MASK));
      tick();
    end
    repeat (4) tick();

    // Back to zero, then a three-step jump 0 -> gray 02 (binary 3).
    r_in = '0;
    repeat (4) tick();
    r_in = 5'h02;
    tick();
    tick();
    tick();
    chk("jump3 d0.delta", 16'(if0.sync_delta), 16'(3));
    chk("jump3 d0.adv",   16'(if0.sync_adv),   16'(1));
    tick();
    chk("jump3 d0.delta after", 16'(if0.sync_delta), 16'(0));
    chk("jump3 d0.adv after",   16'(if0.sync_adv),   16'(0));

    // Illegal two-bit jump 00 -> 03.
    r_in = '0;
    repeat (4) tick();
    r_in = 5'h03;
    tick();
    tick();
    chk("illegal d0.err early", 16'(if0.sync_err), 16'(0));
    tick();
    chk("illegal d0.err set", 16'(if0.sync_err), 16'(1));
    chk("illegal d1.err off", 16'(if1.sync_err), 16'(0));
    repeat (3) tick();
    chk("illegal d0.err sticky", 16'(if0.sync_err), 16'(1));
    r_clr = 1'b1;
    tick();
    r_clr = 1'b0;
    chk("illegal d0.err cleared", 16'(if0.sync_err), 16'(0));

    // Clear coinciding with a fresh violation 03 -> 00: set wins.
    r_in = '0;
    tick();
    tick();
    r_clr = 1'b1;
    tick();
    r_clr = 1'b0;
    chk("set-vs-clr d0.err", 16'(if0.sync_err), 16'(1));
    r_clr = 1'b1;
    tick();
    r_clr = 1'b0;

    // Random traffic: mostly single gray steps, some holds, occasional arbitrary jumps.
    b = 0;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 11)      b = (b + 1) & MASK;
      else if (r > 12) b = int'($urandom_range(0, MASK));
      r_in  = W'(b2g(b));
      r_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    r_clr = 1'b0;

    // Mid-stream reset with 0C on the chain output, then release holding 0C.
    r_in = 5'h0C;
    repeat (5) tick();
    chk("pre-reset d0.out", 16'(if0.sync_out), 16'(5'h0C));
    #2;
    assert_reset(2);
    chk("mid-reset d0.out",   16'(if0.sync_out),   16'(0));
    chk("mid-reset d0.valid", 16'(if0.sync_valid), 16'(0));
    warmup_checks("rerst");
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
